// File: rtl/mine_placer_pkg.sv
// Shared game constants, board-level sizes and the placement FSM state type.
package mine_placer_pkg;
  localparam int MAX_SIZE    = 16;
  localparam int XY_W        = 4;
  localparam int CNT_W       = 8;
  localparam int SIZE_EASY   = 8;
  localparam int SIZE_MEDIUM = 12;
  localparam int SIZE_HARD   = 16;

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} mp_state_t;
endpackage

// File: rtl/mine_cursor.sv
// Board cursor: one step per cycle by 1+y_inc cells, x overflow carries into y, y wraps to 0.
// Registered outputs; no backpressure, step_i simply holds or advances the position.
module mine_cursor #(
  parameter int XY_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            step_i,
  input  logic [1:0]      y_inc_i,
  input  logic [XY_W:0]   board_size_i,
  output logic [XY_W-1:0] cx_o,
  output logic [XY_W-1:0] cy_o
);
  logic [XY_W-1:0] cx_q, cx_d, cy_q, cy_d, nx_wrap;
  logic [XY_W+1:0] nx_sum;
  logic [XY_W:0]   ny_inc;

  always_comb begin
    nx_sum  = {2'b00, cx_q} + (XY_W+2)'(y_inc_i) + (XY_W+2)'(1);
    nx_wrap = XY_W'(nx_sum - {1'b0, board_size_i});
    ny_inc  = {1'b0, cy_q} + (XY_W+1)'(1);
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (clr_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step_i) begin
      // board_size >= 8 and the skip is at most 4, so one subtraction always lands on the board
      if (nx_sum >= {1'b0, board_size_i}) begin
        cx_d = nx_wrap;
        cy_d = (ny_inc >= board_size_i) ? '0 : ny_inc[XY_W-1:0];
      end else begin
        cx_d = nx_sum[XY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o = cx_q;
  assign cy_o = cy_q;
endmodule

// File: rtl/mine_placer.sv
// Scatters mines over the board from a random bit stream, never on the safe cell or twice per cell.
// One cell evaluated per cycle; mine_wr/done are registered pulses; random_data=0 simply stalls placement.
module mine_placer
  import mine_placer_pkg::*;
#(
  parameter int MAX_SIZE = mine_placer_pkg::MAX_SIZE,
  parameter int XY_W     = mine_placer_pkg::XY_W,
  parameter int CNT_W    = mine_placer_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XY_W:0]    board_size,
  input  logic [CNT_W-1:0] mine_num,
  input  logic [XY_W-1:0]  safe_x,
  input  logic [XY_W-1:0]  safe_y,
  input  logic             random_data,
  input  logic [1:0]       y_inc,
  input  logic [XY_W-1:0]  rd_x,
  input  logic [XY_W-1:0]  rd_y,
  output logic             is_mine,
  output logic             mine_wr,
  output logic [XY_W-1:0]  mine_x,
  output logic [XY_W-1:0]  mine_y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] placed
);
  localparam int SQ_W = 2*(XY_W+1);

  mp_state_t                          state_q;
  logic [MAX_SIZE-1:0][MAX_SIZE-1:0]  bitmap_q;
  logic [XY_W:0]                      bs_q;
  logic [XY_W-1:0]                    sx_q, sy_q, mine_x_q, mine_y_q, cx, cy;
  logic [CNT_W-1:0]                   target_q, target_d, placed_q;
  logic [SQ_W-1:0]                    bs_ext, cells_m1;
  logic                               busy_q, done_q, mine_wr_q, place, last_mine;

  // The safe cell is excluded, so at most board_size^2-1 mines fit.
  assign bs_ext   = SQ_W'(board_size);
  assign cells_m1 = bs_ext * bs_ext - SQ_W'(1);
  assign target_d = (SQ_W'(mine_num) > cells_m1) ? CNT_W'(cells_m1) : mine_num;

  assign place = (state_q == PLACE) && random_data
               && !((cx == sx_q) && (cy == sy_q)) && !bitmap_q[cy][cx];
  assign last_mine = (placed_q + CNT_W'(1)) == target_q;

  mine_cursor #(.XY_W(XY_W)) u_cursor (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q == CLEAR),
    .step_i       (state_q == PLACE),
    .y_inc_i      (y_inc),
    .board_size_i (bs_q),
    .cx_o         (cx),
    .cy_o         (cy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bitmap_q  <= '0;
      bs_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      target_q  <= '0;
      placed_q  <= '0;
      mine_x_q  <= '0;
      mine_y_q  <= '0;
      mine_wr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mine_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bs_q     <= board_size;
            sx_q     <= safe_x;
            sy_q     <= safe_y;
            target_q <= target_d;
            busy_q   <= 1'b1;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          bitmap_q <= '0;
          placed_q <= '0;
          if (target_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= PLACE;
          end
        end
        PLACE: begin
          if (place) begin
            bitmap_q[cy][cx] <= 1'b1;
            mine_wr_q        <= 1'b1;
            mine_x_q         <= cx;
            mine_y_q         <= cy;
            placed_q         <= placed_q + CNT_W'(1);
            if (last_mine) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign is_mine = ({1'b0, rd_x} < bs_q) && ({1'b0, rd_y} < bs_q) && bitmap_q[rd_y][rd_x];
  assign mine_wr = mine_wr_q;
  assign mine_x  = mine_x_q;
  assign mine_y  = mine_y_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign placed  = placed_q;
endmodule

// File: tb/tb_mine_placer.sv
// Random-stream bench: a linear-position model predicts the full output timeline of each run.
module tb_mine_placer;
  import mine_placer_pkg::*;

  localparam int MAXJ = 8000;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0, random_data = 1'b0;
  logic [XY_W:0]    board_size = 5'd8;
  logic [CNT_W-1:0] mine_num = '0;
  logic [XY_W-1:0]  safe_x = '0, safe_y = '0, rd_x = '0, rd_y = '0;
  logic [1:0]       y_inc = 2'd0;
  logic             is_mine, mine_wr, busy, done;
  logic [XY_W-1:0]  mine_x, mine_y;
  logic [CNT_W-1:0] placed;

  mine_placer dut (
    .clk(clk), .rst(rst), .start(start), .board_size(board_size), .mine_num(mine_num),
    .safe_x(safe_x), .safe_y(safe_y), .random_data(random_data), .y_inc(y_inc),
    .rd_x(rd_x), .rd_y(rd_y), .is_mine(is_mine), .mine_wr(mine_wr), .mine_x(mine_x),
    .mine_y(mine_y), .busy(busy), .done(done), .placed(placed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_edge = 0, prev_placed = 0;
  bit chk_en = 1'b0;

  bit       s_rnd[MAXJ+2];
  bit       s_st[MAXJ+2];
  bit [1:0] s_inc[MAXJ+2];
  bit       e_wr[MAXJ];
  int       e_pos[MAXJ];
  int       e_cnt[MAXJ];
  bit       mmap[256];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge E0 accepts start; evaluation at edge j>=2 uses the stream bits present at that edge.
  // The cursor is a linear position that advances by 1+y_inc modulo bs*bs.
  task automatic predict(input int bs, input int mines, input int sx, input int sy);
    int cells, tgt, p, n, x, y;
    cells = bs * bs;
    tgt   = (mines < cells - 1) ? mines : cells - 1;
    p = 0; n = 0; done_edge = (tgt == 0) ? 1 : -1;
    foreach (mmap[i]) mmap[i] = 1'b0;
    for (int j = 0; j < MAXJ; j++) begin
      e_wr[j] = 1'b0;
      e_pos[j] = 0;
      if (j >= 2 && done_edge < 0) begin
        x = p % bs;
        y = p / bs;
        if (s_rnd[j] && !(x == sx && y == sy) && !mmap[y*16+x]) begin
          mmap[y*16+x] = 1'b1;
          n++;
          e_wr[j]  = 1'b1;
          e_pos[j] = y*16 + x;
          if (n == tgt) done_edge = j;
        end
        p = (p + 1 + int'(s_inc[j])) % cells;
      end
      e_cnt[j] = (j == 0) ? prev_placed : n;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("busy", int'(busy), int'(cyc < done_edge));
      chk("done", int'(done), int'(cyc == done_edge));
      chk("mine_wr", int'(mine_wr), int'(e_wr[cyc]));
      chk("placed", int'(placed), e_cnt[cyc]);
      if (e_wr[cyc]) chk("mine_xy", int'(mine_y)*16 + int'(mine_x), e_pos[cyc]);
    end
  end

  task automatic scan(input int bs, input bit all_zero);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        rd_x = 4'(x); rd_y = 4'(y);
        #1;
        chk("is_mine", int'(is_mine), (!all_zero && x < bs && y < bs) ? int'(mmap[y*16+x]) : 0);
      end
  endtask

  task automatic run(input int bs, input int mines, input int sx, input int sy,
                     input bit rnd_mode, input int fixed_inc, input int abort_j);
    int last;
    for (int j = 0; j < MAXJ + 2; j++) begin
      s_rnd[j] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      s_inc[j] = rnd_mode ? 2'($urandom_range(0, 3)) : 2'(fixed_inc);
      s_st[j]  = 1'b0;
    end
    predict(bs, mines, sx, sy);
    if (done_edge < 0 || done_edge > MAXJ - 4) begin
      n_bad++;
      $display("FAIL stream_budget: model found no completion within %0d cycles", MAXJ);
      return;
    end
    for (int j = 2; j < done_edge; j++) s_st[j] = rnd_mode && ($urandom_range(0, 7) == 0);
    last = (abort_j > 0) ? abort_j : done_edge + 2;
    @(negedge clk);
    board_size = 5'(bs); mine_num = CNT_W'(mines); safe_x = 4'(sx); safe_y = 4'(sy);
    start = 1'b1; random_data = s_rnd[0]; y_inc = s_inc[0];
    for (int j = 0; j <= last; j++) begin
      @(posedge clk);
      #2;
      cyc = j; chk_en = 1'b1;
      start = s_st[j+1]; random_data = s_rnd[j+1]; y_inc = s_inc[j+1];
      if (rnd_mode) begin
        board_size = 5'($urandom_range(8, 16)); mine_num = CNT_W'($urandom);
        safe_x = 4'($urandom); safe_y = 4'($urandom);
      end
    end
    @(negedge clk);
    #1 chk_en = 1'b0;
    if (abort_j > 0) begin
      rst = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_placed", int'(placed), 0);
      chk("rst_mine_wr", int'(mine_wr), 0);
      chk("rst_mine_xy", int'(mine_x) + int'(mine_y), 0);
      scan(bs, 1'b1);
      prev_placed = 0;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      prev_placed = e_cnt[done_edge];
      scan(bs, 1'b0);
    end
  endtask

  initial begin
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_mine_wr", int'(mine_wr), 0);
    chk("reset_placed", int'(placed), 0);
    chk("reset_mine_xy", int'(mine_x) + int'(mine_y), 0);
    chk("reset_is_mine", int'(is_mine), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run(SIZE_EASY, 10, 0, 0, 1'b0, 0, 0);
    chk("pin_basic_done_edge", done_edge, 12);
    chk("pin_basic_safe_skip", int'(e_wr[2]), 0);
    chk("pin_basic_first", e_pos[3], 1);
    chk("pin_basic_row1", e_pos[10], 16);
    chk("pin_basic_last", e_pos[12], 18);
    chk("basic_placed", int'(placed), 10);

    run(8, 3, 7, 7, 1'b0, 3, 0);
    chk("pin_skip_done_edge", done_edge, 4);
    chk("pin_skip_m0", e_pos[2], 0);
    chk("pin_skip_m1", e_pos[3], 4);
    chk("pin_skip_m2", e_pos[4], 16);

    run(8, 100, 3, 3, 1'b1, 0, 0);
    chk("clamp_placed", int'(placed), 63);
    rd_x = 4'd3; rd_y = 4'd3;
    #1 chk("clamp_safe_cell", int'(is_mine), 0);

    run(SIZE_MEDIUM, 0, 5, 5, 1'b1, 0, 0);
    chk("pin_zero_done_edge", done_edge, 1);

    run(SIZE_HARD, 200, 9, 4, 1'b1, 0, 40);
    run(SIZE_HARD, 200, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1, 0, 0);
    run(SIZE_EASY, 20, 7, 0, 1'b1, 0, 0);
    rd_x = 4'd9; rd_y = 4'd2;
    #1 chk("oob_9_2", int'(is_mine), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
